ccff_chain_loader: RTL and testbench

//  Bitstream source for the configuration-chain (ccff) shift register that runs through switch and connection blocks.
//  - Accepts configuration bytes from a host over a valid/ready stream.
//  - Serialises them MSB-first onto ccff_head, qualified by a shift enable, for exactly CHAIN_LEN bits.
//  - Optional verify pass: the host resends the same stream and the block compares the bits returning on ccff_tail.

---
 rtl/ccff_chain_loader_pkg.sv | 6 +
 rtl/ccff_chain_loader_if.sv | 14 +
 rtl/ccff_byte_serializer.sv | 64 ++++++
 rtl/ccff_chain_loader.sv | 119 +++++++++++
 tb/tb_ccff_chain_loader.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared state encoding and byte width for the configuration-chain loader.
package ccff_loader_pkg;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, DONE, ERROR} state_t;
endpackage

// File: rtl/ccff_chain_loader_if.sv
// Host byte stream plus serial chain connections of the loader.
interface ccff_chain_loader_if;
  import ccff_loader_pkg::*;

  logic [BYTE_W-1:0] cfg_data;
  logic              cfg_valid;
  logic              cfg_ready;
  logic              ccff_head;
  logic              ccff_shift;
  logic              ccff_tail;

  modport master (output cfg_data, cfg_valid, ccff_tail, input cfg_ready, ccff_head, ccff_shift);
  modport slave  (input cfg_data, cfg_valid, ccff_tail, output cfg_ready, ccff_head, ccff_shift);
endinterface

// File: rtl/ccff_byte_serializer.sv
// One-byte holding register that presents bits MSB-first on a registered head/shift pair.
module ccff_byte_serializer
  import ccff_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              take_en,
  input  logic              issue_en,
  input  logic [3:0]        last_bits,
  input  logic [BYTE_W-1:0] data,
  input  logic              valid,
  output logic              ready,
  output logic              head,
  output logic              shift
);
  logic [BYTE_W-1:0] hold_reg;
  logic [2:0]        ptr_reg;
  logic              full_reg;
  logic              head_reg;
  logic              shift_reg;
  logic              issue;
  logic              emptying;
  logic              load;
  logic [2:0]        stop_ptr;

  // A truncated final byte empties as soon as its last used bit goes out.
  assign stop_ptr = 3'(last_bits - 4'd1);
  assign issue    = full_reg & issue_en;
  assign emptying = issue & (ptr_reg == stop_ptr);
  assign ready    = take_en & (~full_reg | emptying);
  assign load     = valid & ready;
  assign head     = head_reg;
  assign shift    = shift_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg  <= '0;
      ptr_reg   <= '0;
      full_reg  <= 1'b0;
      head_reg  <= 1'b0;
      shift_reg <= 1'b0;
    end else if (clear) begin
      hold_reg  <= '0;
      ptr_reg   <= '0;
      full_reg  <= 1'b0;
      shift_reg <= 1'b0;
    end else begin
      shift_reg <= issue;
      if (issue) begin
        head_reg <= hold_reg[3'(BYTE_W-1) - ptr_reg];
        ptr_reg  <= ptr_reg + 3'd1;
      end
      if (load) begin
        hold_reg <= data;
        full_reg <= 1'b1;
        ptr_reg  <= '0;
      end else if (emptying) begin
        hold_reg <= '0;
        full_reg <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a CHAIN_LEN-bit configuration chain from a byte stream, with an optional read-back verify pass.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter  int CHAIN_LEN = 64,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 start,
  input  logic                 verify_en,
  ccff_chain_loader_if.slave   bus,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     err_bit
);
  localparam int N_BYTES   = (CHAIN_LEN + BYTE_W - 1) / BYTE_W;
  localparam int TAIL_BITS = CHAIN_LEN - (N_BYTES - 1) * BYTE_W;
  localparam int BL_W      = $clog2(2 * N_BYTES + 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [CNT_W-1:0]  err_bit_reg, err_bit_next;
  logic [BL_W-1:0]   left_reg, left_next;
  logic              verify_reg, verify_next;
  logic              armed_reg;
  logic              start_ok, last_shift, mismatch, took, final_byte;
  logic              take_en, issue_en;
  logic [3:0]        last_bits;

  // armed_reg keeps a start coinciding with reset release from being taken.
  assign start_ok   = start & armed_reg & (state_reg inside {IDLE, DONE, ERROR});
  assign last_shift = bus.ccff_shift & (cnt_reg == CNT_W'(CHAIN_LEN - 1));
  assign mismatch   = (state_reg == VERIFY) & bus.ccff_shift & (bus.ccff_tail != bus.ccff_head);
  assign busy       = (state_reg == LOAD) | (state_reg == VERIFY);
  assign done       = (state_reg == DONE);
  assign error      = (state_reg == ERROR);
  assign err_bit    = err_bit_reg;
  assign took       = bus.cfg_valid & bus.cfg_ready;

  // The held byte is the last of its pass when no bytes or exactly one pass of bytes remain.
  assign final_byte = (left_reg == '0) | (left_reg == BL_W'(N_BYTES));
  assign last_bits  = final_byte ? 4'(TAIL_BITS) : 4'(BYTE_W);
  assign issue_en   = busy & ~mismatch;
  assign take_en    = issue_en & (left_reg != '0);

  ccff_byte_serializer u_ser (
    .clk      (prog_clk),
    .rst_n    (pReset),
    .clear    (start_ok),
    .take_en  (take_en),
    .issue_en (issue_en),
    .last_bits(last_bits),
    .data     (bus.cfg_data),
    .valid    (bus.cfg_valid),
    .ready    (bus.cfg_ready),
    .head     (bus.ccff_head),
    .shift    (bus.ccff_shift)
  );

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    left_next    = left_reg;
    verify_next  = verify_reg;
    err_bit_next = err_bit_reg;
    if (took) left_next = left_reg - BL_W'(1);
    unique case (state_reg)
      IDLE, DONE, ERROR: begin
        if (start_ok) begin
          state_next   = LOAD;
          cnt_next     = '0;
          left_next    = verify_en ? BL_W'(2 * N_BYTES) : BL_W'(N_BYTES);
          verify_next  = verify_en;
          err_bit_next = '0;
        end
      end
      LOAD: begin
        if (last_shift) begin
          cnt_next   = '0;
          state_next = verify_reg ? VERIFY : DONE;
        end else if (bus.ccff_shift) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      VERIFY: begin
        if (mismatch) begin
          state_next   = ERROR;
          err_bit_next = cnt_reg;
        end else if (last_shift) begin
          cnt_next   = '0;
          state_next = DONE;
        end else if (bus.ccff_shift) begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      left_reg    <= '0;
      verify_reg  <= 1'b0;
      err_bit_reg <= '0;
      armed_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      left_reg    <= left_next;
      verify_reg  <= verify_next;
      err_bit_reg <= err_bit_next;
      armed_reg   <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Two loaders (16-bit and 12-bit chains) driven by random byte streams and checked against a bit-level chain model.
module tb_ccff_chain_loader;
  logic       clk = 1'b0;
  logic       pReset = 1'b0;
  logic       start [2];
  logic       verify_en [2];
  logic       cfg_valid [2];
  logic       mclr [2];
  logic [7:0] cfg_data [2];
  logic [15:0] flip_mask [2];
  logic       ready [2], head [2], shift [2], busy [2], done [2], error [2];
  logic [4:0] errb [2];
  logic [15:0] chain_obs [2];
  logic [7:0] bytes [2];
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int L = (gi == 0) ? 16 : 12;
    ccff_chain_loader_if bus ();
    logic [$clog2(L+1)-1:0] eb;
    logic [15:0] chain_reg = '0;
    logic [5:0]  mcnt_reg = '0;

    assign bus.cfg_data  = cfg_data[gi];
    assign bus.cfg_valid = cfg_valid[gi];
    assign bus.ccff_tail = chain_reg[L-1];
    assign ready[gi]     = bus.cfg_ready;
    assign head[gi]      = bus.ccff_head;
    assign shift[gi]     = bus.ccff_shift;
    assign errb[gi]      = 5'(eb);
    assign chain_obs[gi] = chain_reg & 16'((32'd1 << L) - 1);

    ccff_chain_loader #(.CHAIN_LEN(L)) dut (
      .prog_clk (clk),
      .pReset   (pReset),
      .start    (start[gi]),
      .verify_en(verify_en[gi]),
      .bus      (bus),
      .busy     (busy[gi]),
      .done     (done[gi]),
      .error    (error[gi]),
      .err_bit  (eb)
    );

    // Chain model: shifts head in when enabled; optional bit corruption right after the load pass.
    always @(posedge clk) begin
      if (mclr[gi]) mcnt_reg <= '0;
      else if (bus.ccff_shift) begin
        chain_reg <= {chain_reg[14:0], bus.ccff_head} ^ ((mcnt_reg == 6'(L-1)) ? flip_mask[gi] : 16'd0);
        mcnt_reg  <= mcnt_reg + 6'd1;
      end
    end
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  function automatic int len_of(input int d);
    return (d == 0) ? 16 : 12;
  endfunction

  // Expected chain after a load: the first CHAIN_LEN bits of the byte stream, MSB-first.
  function automatic longint exp_chain(input int d);
    int L = len_of(d);
    int nb = (L + 7) / 8;
    longint v = 0;
    for (int i = 0; i < nb; i++) v = (v << 8) | longint'(bytes[i]);
    return v >> (nb * 8 - L);
  endfunction

  // stall: percent idle cycles, or -1 for valid toggling every cycle.
  task automatic run_load(input int d, input bit ver, input int stall, input int inj_k,
                          input int rst_at, input bit glitch);
    int L, nb, ns, idx, shifts, cyc, first, last, exp_shifts;
    bit late_ready, late_shift, hs, aborted, exp_err;
    logic [7:0] stream [$];
    L = len_of(d); nb = (L + 7) / 8; ns = ver ? 2 * nb : nb;
    idx = 0; shifts = 0; cyc = 0; first = -1; last = -1;
    late_ready = 0; late_shift = 0; aborted = 0;
    for (int i = 0; i < ns; i++) stream.push_back(bytes[i % nb]);
    flip_mask[d] = (inj_k >= 0) ? (16'd1 << (L - 1 - inj_k)) : 16'd0;
    @(negedge clk); start[d] = 1'b1; verify_en[d] = ver; mclr[d] = 1'b1;
    @(negedge clk); start[d] = 1'b0; mclr[d] = 1'b0;
    #1 check("start_clr", {done[d], error[d], busy[d]}, 3'b001);
    while (cyc < 400) begin
      @(negedge clk);
      start[d] = glitch && (cyc == 6);
      if (glitch && cyc == 6) verify_en[d] = ~ver;
      cfg_valid[d] = (idx < ns) && ((stall < 0) ? (cyc % 2 == 0) : ($urandom_range(0, 99) >= stall));
      cfg_data[d] = (idx < ns) ? stream[idx] : 8'($urandom());
      #1;
      if (shift[d]) begin
        if (first < 0) first = cyc;
        last = cyc;
        shifts++;
        if (error[d]) late_shift = 1;
      end
      if (rst_at >= 0 && shift[d] && shifts == rst_at + 1) begin
        pReset = 1'b0;
        #1;
        check("rst_busy", busy[d], 0);
        check("rst_shift", shift[d], 0);
        check("rst_head", head[d], 0);
        check("rst_ready", ready[d], 0);
        check("rst_status", {done[d], error[d], errb[d]}, 0);
        aborted = 1;
        break;
      end
      if (ready[d] && (idx >= ns || done[d] || error[d])) late_ready = 1;
      if (done[d] || error[d]) break;
      hs = cfg_valid[d] && ready[d];
      @(posedge clk);
      if (hs) idx++;
      cyc++;
    end
    start[d] = 1'b0;
    if (aborted) begin
      cfg_valid[d] = 1'b0;
      $display("load d=%0d len=%0d reset during bit %0d", d, L, rst_at);
      return;
    end
    repeat (4) begin
      @(negedge clk);
      cfg_valid[d] = (idx < ns);
      #1;
      if (shift[d]) late_shift = 1;
      if (ready[d]) late_ready = 1;
    end
    cfg_valid[d] = 1'b0;
    exp_err = ver && (inj_k >= 0);
    exp_shifts = !ver ? L : (exp_err ? L + inj_k + 1 : 2 * L);
    check("finished", done[d] | error[d], 1);
    check("error", error[d], exp_err);
    check("done", done[d], !exp_err);
    check("busy_end", busy[d], 0);
    check("shifts", shifts, exp_shifts);
    if (exp_err) check("err_bit", errb[d], inj_k);
    else check("chain", chain_obs[d], exp_chain(d));
    check("late_shift", late_shift, 0);
    check("late_ready", late_ready, 0);
    if (stall == 0) check("contiguous", last - first + 1, shifts);
    $display("load d=%0d len=%0d ver=%0d stall=%0d inj=%0d shifts=%0d done=%0b error=%0b err_bit=%0d",
             d, L, ver, stall, inj_k, shifts, done[d], error[d], errb[d]);
  endtask

  initial begin
    int d, k;
    bit ver;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; verify_en[i] = 0; cfg_valid[i] = 0; mclr[i] = 0;
      cfg_data[i] = '0; flip_mask[i] = '0;
    end
    repeat (3) @(negedge clk);
    check("reset_outs", {busy[0], done[0], error[0], shift[0], head[0], ready[0], errb[0]}, 0);
    check("reset_outs12", {busy[1], done[1], error[1], shift[1], head[1], ready[1], errb[1]}, 0);

    // start held in the cycle reset releases must be ignored
    pReset = 1'b1; start[0] = 1'b1;
    @(negedge clk); start[0] = 1'b0;
    #1 check("start_at_release", busy[0], 0);
    repeat (2) @(negedge clk);

    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    run_load(0, 0, 0, -1, -1, 0);
    bytes[0] = 8'hF0; bytes[1] = 8'hA5;
    run_load(1, 1, 0, -1, -1, 0);
    bytes[0] = 8'($urandom()); bytes[1] = 8'($urandom());
    run_load(0, 1, 0, 5, -1, 0);
    bytes[0] = 8'hA5; bytes[1] = 8'h3C;
    run_load(0, 0, -1, -1, -1, 0);
    run_load(0, 0, 0, -1, 7, 0);
    @(negedge clk); pReset = 1'b1;
    repeat (2) @(negedge clk);
    bytes[0] = 8'($urandom()); bytes[1] = 8'($urandom());
    run_load(0, 1, 0, -1, -1, 0);
    run_load(0, 0, 0, -1, -1, 1);
    run_load(1, 1, 20, -1, -1, 1);

    for (int it = 0; it < 20; it++) begin
      d = int'($urandom_range(0, 1));
      ver = 1'($urandom_range(0, 1));
      k = (ver && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len_of(d) - 1)) : -1;
      bytes[0] = 8'($urandom()); bytes[1] = 8'($urandom());
      run_load(d, ver, ($urandom_range(0, 1) == 0) ? 0 : 30, k, -1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
